// File: rtl/latch_word_serializer.sv
// Parallel-in/serial-out stage behind the mux-based latch: captures a word on a
// valid/ready load and shifts it out one bit per accepted serial transfer.
module latch_word_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_ready,
    output logic             ser_valid,
    output logic             ser_data,
    output logic             ser_last,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt;
    logic             load_fire;
    logic             xfer;

    assign busy       = (state == SHIFT);
    assign ser_valid  = busy;
    assign load_ready = (state == IDLE) && !rst;
    assign load_fire  = load_valid && load_ready;
    assign xfer       = ser_valid && ser_ready;
    assign ser_last   = ser_valid && (cnt == LAST_CNT);
    assign ser_data   = ser_valid && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);

    // Zero-filled move toward whichever end feeds ser_data.
    assign shifted = MSB_FIRST ? (sreg << 1) : (sreg >> 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sreg_next[i] = load_fire ? load_data[i] :
                              (xfer ? shifted[i] : sreg[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            sreg <= sreg_next;
            done <= xfer && ser_last;
            if (load_fire) begin
                state <= SHIFT;
                cnt   <= '0;
            end else if (xfer) begin
                if (ser_last) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_latch_word_serializer.sv
// Bench for latch_word_serializer: vector table, hand-written corner sequences and
// a randomized run against a word/index reference model, on three configurations.
module tb_latch_word_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] lv;
    logic [2:0] sr;
    logic [7:0] ld0;
    logic [7:0] ld1;
    logic [0:0] ldw1;
    wire  [2:0] lr;
    wire  [2:0] sv;
    wire  [2:0] sd;
    wire  [2:0] sl;
    wire  [2:0] bz;
    wire  [2:0] dn;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    latch_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(lr[0]), .load_data(ld0),
        .ser_ready(sr[0]), .ser_valid(sv[0]), .ser_data(sd[0]), .ser_last(sl[0]),
        .busy(bz[0]), .done(dn[0])
    );

    latch_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(lr[1]), .load_data(ld1),
        .ser_ready(sr[1]), .ser_valid(sv[1]), .ser_data(sd[1]), .ser_last(sl[1]),
        .busy(bz[1]), .done(dn[1])
    );

    latch_word_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_w1 (
        .clk(clk), .rst(rst), .load_valid(lv[2]), .load_ready(lr[2]), .load_data(ldw1),
        .ser_ready(sr[2]), .ser_valid(sv[2]), .ser_data(sd[2]), .ser_last(sl[2]),
        .busy(bz[2]), .done(dn[2])
    );

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [7:0] stream;
    } vec_t;

    vec_t tbl [8];

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int s, input logic v, input logic [7:0] d, input logic r);
        lv[s] = v;
        sr[s] = r;
        case (s)
            0:       ld0  = d;
            1:       ld1  = d;
            default: ldw1 = d[0];
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input int s, input string tag);
        checkOutput({tag, "_lr"}, lr[s], 0);
        checkOutput({tag, "_sv"}, sv[s], 0);
        checkOutput({tag, "_sd"}, sd[s], 0);
        checkOutput({tag, "_sl"}, sl[s], 0);
        checkOutput({tag, "_busy"}, bz[s], 0);
        checkOutput({tag, "_done"}, dn[s], 0);
    endtask

    task automatic loadWord(input int s, input logic [7:0] d, input string tag);
        applyStimulus(s, 1'b1, d, 1'b1);
        checkOutput({tag, "_ready"}, lr[s], 1);
        tick();
        applyStimulus(s, 1'b0, 8'h00, 1'b1);
    endtask

    // Walk w bits with ser_ready high; stream[w-1] is the first bit expected.
    // With poke set, a competing load of 8'hFF is offered mid-word.
    task automatic checkStream(input int s, input int w, input logic [7:0] stream,
                               input bit poke, input string tag);
        for (int k = 0; k < w; k++) begin
            if (poke && k == 3) applyStimulus(s, 1'b1, 8'hFF, 1'b1);
            if (poke && k == 5) applyStimulus(s, 1'b0, 8'h00, 1'b1);
            checkOutput($sformatf("%s_sv%0d", tag, k), sv[s], 1);
            checkOutput($sformatf("%s_sd%0d", tag, k), sd[s], stream[w-1-k]);
            checkOutput($sformatf("%s_sl%0d", tag, k), sl[s], (k == w - 1) ? 1 : 0);
            checkOutput($sformatf("%s_lr%0d", tag, k), lr[s], 0);
            tick();
        end
        checkOutput({tag, "_done"}, dn[s], 1);
        checkOutput({tag, "_ready_after"}, lr[s], 1);
        checkOutput({tag, "_sv_after"}, sv[s], 0);
    endtask

    initial begin
        logic [7:0] a5;
        logic       m_busy, m_done, nd, v, r, exp_sd;
        logic [7:0] m_word, d;
        int         m_idx, w;
        bit         msb;

        tbl[0] = '{0, 8'h0F, 8'h0F};
        tbl[1] = '{0, 8'hA5, 8'hA5};
        tbl[2] = '{0, 8'h3C, 8'h3C};
        tbl[3] = '{0, 8'h80, 8'h80};
        tbl[4] = '{1, 8'h0F, 8'hF0};
        tbl[5] = '{1, 8'hA5, 8'hA5};
        tbl[6] = '{1, 8'h01, 8'h80};
        tbl[7] = '{1, 8'hC8, 8'h13};

        rst  = 1'b1;
        lv   = '0;
        sr   = '0;
        ld0  = '0;
        ld1  = '0;
        ldw1 = '0;

        tick();
        tick();
        for (int s = 0; s < 3; s++) checkAllZero(s, $sformatf("rst%0d", s));
        #2 rst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            checkOutput($sformatf("rel%0d_lr", s), lr[s], 1);
            checkOutput($sformatf("rel%0d_sv", s), sv[s], 0);
        end
        tick();

        $display("[TB] vector table");
        for (int i = 0; i < 8; i++) begin
            loadWord(tbl[i].sel, tbl[i].data, $sformatf("vec%0d", i));
            checkStream(tbl[i].sel, 8, tbl[i].stream, 1'b0, $sformatf("vec%0d", i));
            tick();
            checkOutput($sformatf("vec%0d_done_clr", i), dn[tbl[i].sel], 0);
        end

        $display("[TB] stall on bit 2");
        a5 = 8'hA5;
        loadWord(0, a5, "stall");
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("stall_pre%0d", k), sd[0], a5[7-k]);
            tick();
        end
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("stall_hold_sd%0d", k), sd[0], 1);
            checkOutput($sformatf("stall_hold_sl%0d", k), sl[0], 0);
            checkOutput($sformatf("stall_hold_sv%0d", k), sv[0], 1);
            tick();
        end
        applyStimulus(0, 1'b0, 8'h00, 1'b1);
        for (int k = 2; k < 8; k++) begin
            checkOutput($sformatf("stall_sd%0d", k), sd[0], a5[7-k]);
            checkOutput($sformatf("stall_sl%0d", k), sl[0], (k == 7) ? 1 : 0);
            checkOutput($sformatf("stall_done_early%0d", k), dn[0], 0);
            tick();
        end
        checkOutput("stall_done", dn[0], 1);
        tick();

        $display("[TB] load while busy and back-to-back");
        loadWord(0, 8'h0F, "busyld");
        checkStream(0, 8, 8'h0F, 1'b1, "busyld");
        applyStimulus(0, 1'b1, 8'hF0, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 8'h00, 1'b1);
        checkStream(0, 8, 8'hF0, 1'b0, "b2b");
        tick();

        $display("[TB] reset mid-word");
        loadWord(0, 8'h5A, "midrst");
        for (int k = 0; k < 4; k++) tick();
        #2 rst = 1'b1;
        #1 checkAllZero(0, "midrst_async");
        tick();
        checkAllZero(0, "midrst_held");
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_rel_lr", lr[0], 1);
        checkOutput("midrst_rel_sv", sv[0], 0);
        tick();
        checkOutput("midrst_no_done", dn[0], 0);
        checkOutput("midrst_idle_sv", sv[0], 0);

        $display("[TB] width 1");
        loadWord(2, 8'h01, "w1a");
        checkStream(2, 1, 8'h01, 1'b0, "w1a");
        tick();
        checkOutput("w1a_done_clr", dn[2], 0);
        loadWord(2, 8'h00, "w1b");
        checkStream(2, 1, 8'h00, 1'b0, "w1b");
        tick();

        $display("[TB] randomized run");
        for (int s = 0; s < 3; s++) begin
            w   = (s == 2) ? 1 : 8;
            msb = (s != 1);
            applyStimulus(s, 1'b0, 8'h00, 1'b0);
            #2 rst = 1'b1;
            tick();
            #2 rst = 1'b0;
            #1;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_word = '0;
            m_idx  = 0;
            for (int c = 0; c < 300; c++) begin
                v = 1'($urandom_range(0, 1));
                r = ($urandom_range(0, 3) != 0);
                d = 8'($urandom);
                if (w == 1) d = {7'd0, d[0]};
                applyStimulus(s, v, d, r);
                exp_sd = m_busy ? (msb ? m_word[w-1-m_idx] : m_word[m_idx]) : 1'b0;
                checkOutput($sformatf("rnd%0d_%0d_lr", s, c), lr[s], !m_busy);
                checkOutput($sformatf("rnd%0d_%0d_sv", s, c), sv[s], m_busy);
                checkOutput($sformatf("rnd%0d_%0d_sd", s, c), sd[s], exp_sd);
                checkOutput($sformatf("rnd%0d_%0d_sl", s, c), sl[s], m_busy && (m_idx == w - 1));
                checkOutput($sformatf("rnd%0d_%0d_busy", s, c), bz[s], m_busy);
                checkOutput($sformatf("rnd%0d_%0d_done", s, c), dn[s], m_done);
                @(posedge clk);
                nd = m_busy && r && (m_idx == w - 1);
                if (!m_busy) begin
                    if (v) begin
                        m_busy = 1'b1;
                        m_word = d;
                        m_idx  = 0;
                    end
                end else if (r) begin
                    if (m_idx == w - 1) m_busy = 1'b0;
                    else m_idx++;
                end
                m_done = nd;
                #1;
            end
            applyStimulus(s, 1'b0, 8'h00, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
